// File: rtl/ring_pkg.sv
// Shared ring definitions: slot-type encodings, message header layout and
// the station state encoding used by the ring station arbiter.
package ring_pkg;

    localparam logic [3:0] TOKEN     = 4'd1;
    localparam logic [3:0] NULL_SLOT = 4'd7;
    localparam logic [3:0] MESSAGE   = 4'd8;

    localparam int HDR_DEST_MSB = 17;
    localparam int HDR_DEST_LSB = 14;
    localparam int HDR_SRC_MSB  = 13;
    localparam int HDR_SRC_LSB  = 10;
    localparam int HDR_TYPE_MSB = 9;
    localparam int HDR_TYPE_LSB = 6;
    localparam int HDR_LEN_MSB  = 5;
    localparam int HDR_LEN_LSB  = 0;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_PASS = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    function automatic logic [31:0] make_header(
        input logic [3:0] dest,
        input logic [3:0] src,
        input logic [3:0] typ,
        input logic [5:0] len
    );
        logic [31:0] hdr;
        hdr = '0;
        hdr[HDR_DEST_MSB:HDR_DEST_LSB] = dest;
        hdr[HDR_SRC_MSB:HDR_SRC_LSB]   = src;
        hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] = typ;
        hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = len;
        return hdr;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo NCLIENTS. The pointer itself is held by the parent.
module rr_picker #(
    parameter int NCLIENTS = 3,
    parameter int IW       = $clog2(NCLIENTS)
) (
    input  logic [NCLIENTS-1:0] req,
    input  logic [IW-1:0]       ptr,
    output logic                valid,
    output logic [IW-1:0]       idx
);

    int cand;

    // NOTE: every output and temporary gets a default first so no path through
    // the loop leaves a value unassigned and infers a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 0; k < NCLIENTS; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NCLIENTS) cand = cand - NCLIENTS;
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/ring_station_arbiter.sv
// Per-core ring station: shares the single ring token among local clients,
// muxes the holder onto the ring and regenerates the token on release.
module ring_station_arbiter
    import ring_pkg::*;
#(
    parameter int NCLIENTS          = 3,
    parameter int MAX_HOLD          = 63,
    parameter int TOKEN_MASTER_CORE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [3:0]               whichCore,
    input  logic [31:0]              RingIn,
    input  logic [3:0]               SlotTypeIn,
    input  logic [3:0]               SourceIn,
    output logic [31:0]              RingOut,
    output logic [3:0]               SlotTypeOut,
    output logic [3:0]               SourceOut,
    input  logic [NCLIENTS-1:0]      clientWantsToken,
    input  logic [NCLIENTS-1:0]      clientDriveRing,
    input  logic [32*NCLIENTS-1:0]   clientRingOut,
    input  logic [4*NCLIENTS-1:0]    clientSlotTypeOut,
    input  logic [4*NCLIENTS-1:0]    clientSourceOut,
    output logic [NCLIENTS-1:0]      clientAcquireToken,
    output logic                     holdErr
);

    localparam int IW = $clog2(NCLIENTS);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD);
    localparam logic [3:0]    MASTER_ID  = 4'(TOKEN_MASTER_CORE);

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_idx;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          take;

    logic [31:0] cl_data [NCLIENTS];
    logic [3:0]  cl_type [NCLIENTS];
    logic [3:0]  cl_src  [NCLIENTS];

    for (genvar i = 0; i < NCLIENTS; i++) begin : g_unpack
        assign cl_data[i] = clientRingOut[32*i +: 32];
        assign cl_type[i] = clientSlotTypeOut[4*i +: 4];
        assign cl_src[i]  = clientSourceOut[4*i +: 4];
    end

    rr_picker #(
        .NCLIENTS (NCLIENTS),
        .IW       (IW)
    ) u_picker (
        .req   (clientWantsToken),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign take      = (state == ST_PASS) && (SlotTypeIn == TOKEN) && pick_valid;
    assign next_ptr  = (pick_idx == IW'(NCLIENTS - 1)) ? '0 : pick_idx + 1'b1;
    assign hold_next = (hold_cnt == '1) ? hold_cnt : hold_cnt + 1'b1;

    // The grant strobe is combinational so the client sees it in the very
    // slot it is allowed to fill.
    always_comb begin
        clientAcquireToken = '0;
        if (take) clientAcquireToken[pick_idx] = 1'b1;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= ST_INIT;
            RingOut     <= '0;
            SlotTypeOut <= NULL_SLOT;
            SourceOut   <= '0;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            hold_cnt    <= '0;
            holdErr     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    RingOut   <= RingIn;
                    SourceOut <= SourceIn;
                    if (whichCore == MASTER_ID) begin
                        SlotTypeOut <= TOKEN;
                        SourceOut   <= whichCore;
                    end else begin
                        SlotTypeOut <= SlotTypeIn;
                    end
                    state <= ST_PASS;
                end

                ST_PASS: begin
                    if (take) begin
                        rr_ptr    <= next_ptr;
                        grant_idx <= pick_idx;
                        hold_cnt  <= HW'(1);
                        if (clientDriveRing[pick_idx]) begin
                            RingOut     <= cl_data[pick_idx];
                            SlotTypeOut <= cl_type[pick_idx];
                            SourceOut   <= cl_src[pick_idx];
                            if (MAX_HOLD <= 1) holdErr <= 1'b1;
                            state <= ST_BUSY;
                        end else begin
                            // Zero-length grant: the token goes straight back out.
                            RingOut     <= '0;
                            SlotTypeOut <= TOKEN;
                            SourceOut   <= whichCore;
                        end
                    end else begin
                        RingOut     <= RingIn;
                        SlotTypeOut <= SlotTypeIn;
                        SourceOut   <= SourceIn;
                    end
                end

                ST_BUSY: begin
                    // Only one token exists on the ring; a second one is a protocol fault.
                    if (SlotTypeIn == TOKEN) holdErr <= 1'b1;
                    if (clientDriveRing[grant_idx]) begin
                        RingOut     <= cl_data[grant_idx];
                        SlotTypeOut <= cl_type[grant_idx];
                        SourceOut   <= cl_src[grant_idx];
                        hold_cnt    <= hold_next;
                        if (hold_next >= HOLD_LIMIT) holdErr <= 1'b1;
                    end else begin
                        RingOut     <= '0;
                        SlotTypeOut <= TOKEN;
                        SourceOut   <= whichCore;
                        state       <= ST_PASS;
                    end
                end

                default: state <= ST_PASS;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_station_arbiter.sv
// Directed bench for ring_station_arbiter: reset, token injection, pass-through,
// round-robin grants, zero-length grants, bursts, hold limit and protocol errors.
module tb_ring_station_arbiter;
    import ring_pkg::*;

    localparam int N = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0]        whichCore;
    logic [31:0]       RingIn;
    logic [3:0]        SlotTypeIn;
    logic [3:0]        SourceIn;
    logic [31:0]       RingOut;
    logic [3:0]        SlotTypeOut;
    logic [3:0]        SourceOut;
    logic [N-1:0]      wants;
    logic [N-1:0]      drive;
    logic [32*N-1:0]   c_ring;
    logic [4*N-1:0]    c_type;
    logic [4*N-1:0]    c_src;
    logic [N-1:0]      acquire;
    logic              holdErr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    ring_station_arbiter #(
        .NCLIENTS          (N),
        .MAX_HOLD          (4),
        .TOKEN_MASTER_CORE (1)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .whichCore          (whichCore),
        .RingIn             (RingIn),
        .SlotTypeIn         (SlotTypeIn),
        .SourceIn           (SourceIn),
        .RingOut            (RingOut),
        .SlotTypeOut        (SlotTypeOut),
        .SourceOut          (SourceOut),
        .clientWantsToken   (wants),
        .clientDriveRing    (drive),
        .clientRingOut      (c_ring),
        .clientSlotTypeOut  (c_type),
        .clientSourceOut    (c_src),
        .clientAcquireToken (acquire),
        .holdErr            (holdErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] d, input logic [3:0] t,
                             input logic [3:0] s);
        check({tag, "_data"}, RingOut, d);
        check({tag, "_type"}, 32'(SlotTypeOut), 32'(t));
        check({tag, "_src"}, 32'(SourceOut), 32'(s));
    endtask

    task automatic idle_inputs();
        RingIn     = '0;
        SlotTypeIn = NULL_SLOT;
        SourceIn   = '0;
        wants      = '0;
        drive      = '0;
        c_ring     = '0;
        c_type     = '0;
        c_src      = '0;
    endtask

    task automatic set_client(input int i, input logic [31:0] d, input logic [3:0] t,
                              input logic [3:0] s);
        c_ring[32*i +: 32] = d;
        c_type[4*i +: 4]   = t;
        c_src[4*i +: 4]    = s;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One token arrival; the granted client drives for the acquire slot only
    // (or not at all), then the released token is checked.
    task automatic token_grant(input string tag, input logic [N-1:0] want, input int exp_g,
                               input logic drive_it, input logic [31:0] base);
        logic [N-1:0] exp_acq;
        @(negedge clock);
        idle_inputs();
        SlotTypeIn = TOKEN;
        RingIn     = 32'hDEAD_0000;
        SourceIn   = 4'h9;
        wants      = want;
        for (int i = 0; i < N; i++) set_client(i, base + 32'(i), MESSAGE, 4'(i));
        drive = drive_it ? '1 : '0;
        #1;
        exp_acq = '0;
        exp_acq[exp_g] = 1'b1;
        check({tag, "_acq"}, 32'(acquire), 32'(exp_acq));
        tick();
        if (drive_it) begin
            check_out({tag, "_word"}, base + 32'(exp_g), MESSAGE, 4'(exp_g));
            @(negedge clock);
            idle_inputs();
            #1;
            check({tag, "_acq_off"}, 32'(acquire), 32'h0);
            tick();
        end
        check_out({tag, "_rel"}, 32'h0, TOKEN, whichCore);
    endtask

    logic [31:0] words [6];

    initial begin
        idle_inputs();
        whichCore = 4'd1;
        reset     = 1'b0;
        repeat (2) tick();

        // Reset state
        check_out("rst", 32'h0, NULL_SLOT, 4'h0);
        check("rst_acq", 32'(acquire), 32'h0);
        check("rst_err", 32'(holdErr), 32'h0);

        // INIT on the token-master core injects the token
        @(negedge clock);
        reset  = 1'b1;
        RingIn = 32'hABCD_0000;
        tick();
        check_out("init_master", 32'hABCD_0000, TOKEN, 4'd1);

        // Message passes through with one cycle of latency
        @(negedge clock);
        idle_inputs();
        RingIn = 32'h0000_1234; SlotTypeIn = MESSAGE; SourceIn = 4'd3;
        tick();
        check_out("pass_msg", 32'h0000_1234, MESSAGE, 4'd3);

        // Token with no requester is forwarded unchanged
        @(negedge clock);
        idle_inputs();
        RingIn = 32'h0000_0055; SlotTypeIn = TOKEN; SourceIn = 4'd2;
        #1;
        check("fwd_acq", 32'(acquire), 32'h0);
        tick();
        check_out("fwd_token", 32'h0000_0055, TOKEN, 4'd2);

        // Round robin with all three clients requesting
        token_grant("rr0", 3'b111, 0, 1'b1, 32'h1000_0000);
        token_grant("rr1", 3'b111, 1, 1'b1, 32'h2000_0000);
        token_grant("rr2", 3'b111, 2, 1'b1, 32'h3000_0000);
        token_grant("rr3", 3'b111, 0, 1'b1, 32'h4000_0000);
        check("rr_err", 32'(holdErr), 32'h0);

        // Zero-length grant to client 1, pointer moves to 2
        token_grant("zero", 3'b010, 1, 1'b0, 32'h5000_0000);
        @(negedge clock);
        idle_inputs();
        RingIn = 32'h0000_0abc; SlotTypeIn = MESSAGE; SourceIn = 4'd6;
        tick();
        check_out("zero_pass", 32'h0000_0abc, MESSAGE, 4'd6);
        token_grant("wrap", 3'b011, 0, 1'b1, 32'h6000_0000);

        // Four-word burst from client 0; client 1 also drives but is ignored
        words[0] = make_header(4'd2, 4'd1, MESSAGE, 6'd3);
        words[1] = 32'hA1A1_0001;
        words[2] = 32'hA2A2_0002;
        words[3] = 32'hA3A3_0003;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            idle_inputs();
            SlotTypeIn = (k == 0) ? TOKEN : MESSAGE;
            RingIn     = 32'hBAD0_0000 + 32'(k);
            wants      = (k == 0) ? 3'b001 : 3'b000;
            drive      = 3'b011;
            set_client(0, words[k], MESSAGE, 4'd1);
            set_client(1, 32'hFFFF_FFFF, MESSAGE, 4'd7);
            #1;
            check($sformatf("burst_acq%0d", k), 32'(acquire), (k == 0) ? 32'h1 : 32'h0);
            tick();
            check_out($sformatf("burst_w%0d", k), words[k], MESSAGE, 4'd1);
            if (k == 2) check("burst_err_pre", 32'(holdErr), 32'h0);
        end
        check("burst_err_limit", 32'(holdErr), 32'h1);
        @(negedge clock);
        idle_inputs();
        tick();
        check_out("burst_rel", 32'h0, TOKEN, 4'd1);

        // Non-master core: reset clears holdErr and INIT just passes through
        @(negedge clock);
        reset = 1'b0;
        whichCore = 4'd5;
        #1;
        check("rst2_err", 32'(holdErr), 32'h0);
        @(negedge clock);
        reset  = 1'b1;
        RingIn = 32'h0000_0077; SourceIn = 4'd4;
        tick();
        check_out("init_slave", 32'h0000_0077, NULL_SLOT, 4'd4);

        // Six-word hold from client 2, then reset mid-burst
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            idle_inputs();
            SlotTypeIn = (k == 0) ? TOKEN : NULL_SLOT;
            wants      = (k == 0) ? 3'b100 : 3'b000;
            drive      = 3'b100;
            set_client(2, 32'hC000_0000 + 32'(k), MESSAGE, 4'd2);
            #1;
            if (k == 0) check("hold_acq", 32'(acquire), 32'h4);
            tick();
            check_out($sformatf("hold_w%0d", k), 32'hC000_0000 + 32'(k), MESSAGE, 4'd2);
            check($sformatf("hold_err%0d", k), 32'(holdErr), (k >= 3) ? 32'h1 : 32'h0);
        end
        reset = 1'b0;
        #1;
        check_out("mid_rst", 32'h0, NULL_SLOT, 4'h0);
        check("mid_rst_err", 32'(holdErr), 32'h0);
        check("mid_rst_acq", 32'(acquire), 32'h0);
        @(negedge clock);
        idle_inputs();
        reset = 1'b1;
        tick();
        check_out("init_slave2", 32'h0, NULL_SLOT, 4'h0);

        // Token arriving while BUSY is dropped and flagged
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            idle_inputs();
            SlotTypeIn = (k < 2) ? TOKEN : MESSAGE;
            wants      = (k == 0) ? 3'b010 : 3'b000;
            drive      = 3'b010;
            set_client(1, 32'hD000_0000 + 32'(k), MESSAGE, 4'd1);
            tick();
            check_out($sformatf("dup_w%0d", k), 32'hD000_0000 + 32'(k), MESSAGE, 4'd1);
            check($sformatf("dup_err%0d", k), 32'(holdErr), (k >= 1) ? 32'h1 : 32'h0);
        end
        @(negedge clock);
        idle_inputs();
        tick();
        check_out("dup_rel", 32'h0, TOKEN, 4'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ring_station_arbiter.md
Name: ring_station_arbiter

Overview:
- Per-core ring station that shares the core's single ring-token slot among N local ring clients: the messenger, the lock unit, the cache-miss unit, and similar.
- Observes the incoming ring. When a Token slot arrives and at least one client wants it, the block consumes the token, grants it round-robin, and muxes the granted client's header/payload onto the ring. When the client finishes, it regenerates the Token.
- With no requester, the ring passes through with one cycle of latency.
- On the token-master core, it injects the single initial Token after reset.

Parameters:
- NCLIENTS, 3, number of local ring clients (2..8).
- MAX_HOLD, 63, cycle limit for one grant before holdErr is flagged.
- TOKEN_MASTER_CORE, 1, whichCore value that injects the initial Token.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- whichCore  in  4  this core's number.
- RingIn  in  32  upstream ring data.
- SlotTypeIn  in  4  upstream slot type.
- SourceIn  in  4  upstream slot source.
- RingOut  out  32  downstream ring data, registered.
- SlotTypeOut  out  4  downstream slot type, registered.
- SourceOut  out  4  downstream source, registered.
- clientWantsToken  in  NCLIENTS  per-client request.
- clientDriveRing  in  NCLIENTS  per-client "driving this cycle".
- clientRingOut  in  32*NCLIENTS  client data; client i occupies bits [32i+31:32i].
- clientSlotTypeOut  in  4*NCLIENTS  client slot types.
- clientSourceOut  in  4*NCLIENTS  client sources.
- clientAcquireToken  out  NCLIENTS  one-hot, one-cycle grant strobe.
- holdErr  out  1  sticky: a grant exceeded MAX_HOLD.

Behaviour:
- Slot type encodings: Token=1, Null=7, Message=8.
- Reset while reset==0, any state:
  - state=INIT; RingOut=0; SlotTypeOut=Null; SourceOut=0.
  - clientAcquireToken=0; rrPtr=0; holdCnt=0; holdErr=0.
  - A mid-burst reset abandons the grant. No Token is emitted until INIT completes.
- Ring outputs are registered at the end of each cycle:
  - PASS: RingOut <= RingIn, SlotTypeOut <= SlotTypeIn, SourceOut <= SourceIn.
  - GRANT/BUSY with clientDriveRing[g]=1: outputs <= client g's fields.
  - Otherwise the outputs take the value defined by the state below.
- State machine:
  - INIT (1 cycle):
    - If whichCore==TOKEN_MASTER_CORE, emit {Token, RingIn data, SourceOut=whichCore}.
    - Else pass through.
    - Next state: PASS.
  - PASS:
    - If SlotTypeIn==Token and |clientWantsToken, then g = first requester at or after rrPtr, wrapping modulo NCLIENTS.
    - The same cycle: assert clientAcquireToken[g] combinationally and drive the client mux for g. The token is not forwarded.
    - Next state: BUSY. rrPtr <= g+1 mod NCLIENTS. holdCnt <= 1.
    - If SlotTypeIn==Token with no requester: forward the Token unchanged.
  - BUSY:
    - While clientDriveRing[g]==1: drive client g; holdCnt increments, saturating.
    - If holdCnt reaches MAX_HOLD, set holdErr. The grant is never truncated.
    - First cycle with clientDriveRing[g]==0: emit {Token, data 0, SourceOut=whichCore}. Next state: PASS.
- Zero-drive grant: if clientDriveRing[g]==0 in the acquire cycle, emit Token in that slot and return to PASS. This is a zero-length release; no wasted slot.
- clientWantsToken dropping after a grant has no effect. Only clientDriveRing ends a grant.
- Simultaneous requests: exactly one grant per Token arrival.
- Round-robin fairness: every requester is granted within NCLIENTS token visits.
- Incoming slots are overwritten while BUSY. This is legal because only the token holder transmits.
- A Token arriving while BUSY indicates a protocol error. It is dropped and holdErr is set.
- Client driveRing from a non-granted client is ignored.

Decomposition:
- Shared package ring_pkg holds:
  - slot-type constants: TOKEN, NULL_SLOT, MESSAGE;
  - header field positions: dest[17:14], src[13:10], type[9:6], len[5:0];
  - the state enum.
- Natural sub-module rr_picker: a combinational round-robin first-one-from-pointer over NCLIENTS, with a registered pointer update done in the parent.

Test Plan:
- Reset release with whichCore=1 → the cycle after INIT, SlotTypeOut=1 and SourceOut=1. With whichCore=5 → pass-through; no Token emitted.
- Token in, client0 wants, drives 4 cycles (header plus 3 payload words) → acquire[0] high for exactly 1 cycle; RingOut carries the 4 client words with 1-cycle latency; the 5th slot is Token with SourceOut=whichCore.
- Clients 0, 1, 2 all want across three Token arrivals → grants in order 0, 1, 2; a fourth arrival with all still wanting → client 0.
- Token in, no requests; RingIn=0x1234 with SlotTypeIn=8 on the prior cycle → passed unchanged one cycle later; Token forwarded.
- Zero-length grant (drive=0 at acquire) → Token re-emitted in the same slot; state back to PASS; rrPtr advanced.
- MAX_HOLD=4, client drives 6 cycles → holdErr set after cycle 4, all 6 words forwarded. Asserting reset=0 mid-burst → outputs Null/0 immediately; holdErr cleared.
